uart_core: RTL and testbench



---
 rtl/uart_core_if.sv | 20 ++
 rtl/uart_core.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_if.sv
// Register-file side of uart_core: transmit/config lanes toward the core,
// received byte and status lanes back to the register file.
interface uart_core_if;
  logic       send_req;
  logic [7:0] uart_send_byte;
  logic [7:0] uart_cfg;
  logic       rx_clr;
  logic [7:0] uart_rcvd_byte;
  logic [7:0] uart_status;

  modport master (
    output send_req, uart_send_byte, uart_cfg, rx_clr,
    input  uart_rcvd_byte, uart_status
  );

  modport slave (
    input  send_req, uart_send_byte, uart_cfg, rx_clr,
    output uart_rcvd_byte, uart_status
  );
endinterface

// File: rtl/uart_core.sv
// UART serial engine: independent TX/RX bit FSMs behind the register word.
// Optional even parity is enabled by defining UART_PARITY_EN.
module uart_core #(
  parameter int DIV_MIN = 2
) (
  input  logic        clk,
  input  logic        rstb,
  uart_core_if.slave  bus,
  input  logic        rxd,
  output logic        txd
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [7:0] DIV_FLOOR = 8'(DIV_MIN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic [7:0] div_c;

  always_comb begin
    div_c = (bus.uart_cfg < DIV_FLOOR) ? DIV_FLOOR : bus.uart_cfg;
  end

  state_e     tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] tx_div_q, tx_div_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       tx_par_q, tx_par_d;
  logic       txd_q, txd_d;

  // txd is registered and loaded with the level of the bit being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    if (tx_state_q == ST_IDLE) begin
      txd_d = 1'b1;
      if (bus.send_req) begin
        tx_state_d = ST_START;
        tx_div_d   = div_c;
        tx_cnt_d   = div_c - 8'd1;
        tx_shift_d = bus.uart_send_byte;
        tx_par_d   = ^bus.uart_send_byte;
        tx_bit_d   = 3'd0;
        txd_d      = 1'b0;
      end
    end else if (tx_cnt_q != 8'd0) begin
      tx_cnt_d = tx_cnt_q - 8'd1;
    end else begin
      tx_cnt_d = tx_div_q - 8'd1;
      case (tx_state_q)
        ST_START: begin
          tx_state_d = ST_DATA;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end
        ST_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
            txd_d      = PAR_EN ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
        ST_PARITY: begin
          tx_state_d = ST_STOP;
          txd_d      = 1'b1;
        end
        default: begin
          tx_state_d = ST_IDLE;
          txd_d      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= 8'd0;
      tx_div_q   <= 8'd0;
      tx_shift_q <= 8'd0;
      tx_bit_q   <= 3'd0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  // sync_q[1] is the synchronised rxd; sync_q[2] is its previous value for edge detection.
  logic [2:0] sync_q, sync_d;
  logic       rx_sample;
  logic       rx_fall;

  state_e     rx_state_q, rx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_div_q, rx_div_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_par_q, rx_par_d;
  logic       rx_done;
  logic [7:0] rcvd_q, rcvd_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       perr_q, perr_d;

  always_comb begin
    sync_d    = {sync_q[1:0], rxd};
    rx_sample = sync_q[1];
    rx_fall   = sync_q[2] & ~sync_q[1];
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    rcvd_d     = rcvd_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    if (rx_state_q == ST_IDLE) begin
      if (rx_fall) begin
        rx_state_d = ST_START;
        rx_div_d   = div_c;
        rx_cnt_d   = (div_c >> 1) - 8'd1;
      end
    end else if (rx_cnt_q != 8'd0) begin
      rx_cnt_d = rx_cnt_q - 8'd1;
    end else begin
      rx_cnt_d = rx_div_q - 8'd1;
      case (rx_state_q)
        ST_START: begin
          rx_state_d = rx_sample ? ST_IDLE : ST_DATA;
          rx_bit_d   = 3'd0;
        end
        ST_DATA: begin
          rx_shift_d = {rx_sample, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          rx_par_d   = rx_sample;
          rx_state_d = ST_STOP;
        end
        default: begin
          rx_state_d = ST_IDLE;
          rx_done    = 1'b1;
        end
      endcase
    end
    // A completion in the same cycle as rx_clr behaves as if the buffer were empty.
    if (rx_done) begin
      if (valid_q && !bus.rx_clr) begin
        ovr_d = 1'b1;
      end else begin
        rcvd_d  = rx_shift_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
        ferr_d  = ~rx_sample;
        perr_d  = PAR_EN & ((^rx_shift_q) ^ rx_par_q);
      end
    end else if (bus.rx_clr) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q     <= 3'b111;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= 8'd0;
      rx_div_q   <= 8'd0;
      rx_shift_q <= 8'd0;
      rx_bit_q   <= 3'd0;
      rx_par_q   <= 1'b0;
      rcvd_q     <= 8'd0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_par_q   <= rx_par_d;
      rcvd_q     <= rcvd_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  assign txd                = txd_q;
  assign bus.uart_rcvd_byte = rcvd_q;
  assign bus.uart_status    = {3'b000, PAR_EN ? perr_q : 1'b0, ferr_q, ovr_q, valid_q,
                               tx_state_q != ST_IDLE};

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: TX waveform table, hand-written RX corner sequences,
// and randomized RX frames checked against a transaction-level status model.
module tb_uart_core;

`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int L   = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int L   = 10;
`endif

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic rxd_tb = 1'b1;
  logic loop_en = 1'b0;
  logic rxd;
  logic txd;

  uart_core_if bus();

  assign rxd = loop_en ? txd : rxd_tb;

  uart_core #(.DIV_MIN(2)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus),
    .rxd  (rxd),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_byte = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_perr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cfg;
    int         poke;
    int         exp_n;
    logic       exp_par;
  } tx_vec_t;

  tx_vec_t tx_tab[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input logic ferr, input logic perr,
                                      input logic clr_same);
    if (m_valid && !clr_same) begin
      m_ovr = 1'b1;
    end else begin
      m_byte  = d;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
      m_ferr  = ferr;
      m_perr  = perr;
    end
  endfunction

  function automatic logic [7:0] model_status();
    return {3'b000, m_perr, m_ferr, m_ovr, m_valid, 1'b0};
  endfunction

  // Level of serial bit k of a frame (k = 0 is the start bit).
  function automatic logic frame_bit(input logic [7:0] d, input int k, input logic par,
                                     input logic stop_v);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PAR && k == 9) return par;
    if (k == L - 1) return stop_v;
    return 1'b1;
  endfunction

  // Sends one byte and checks every cycle of the frame; leaves the bench in the
  // first idle cycle so the next vector is sent back-to-back.
  task automatic apply_stimulus(input tx_vec_t v, input int idx);
    logic [10:0] bit_bad;
    logic        busy_bad;
    int          k;
    bit_bad  = '0;
    busy_bad = 1'b0;
    bus.uart_cfg       = v.cfg;
    bus.uart_send_byte = v.data;
    bus.send_req       = 1'b1;
    @(posedge clk); #1;
    bus.send_req       = 1'b0;
    bus.uart_send_byte = 8'($urandom);
    bus.uart_cfg       = 8'($urandom);
    for (int c = 1; c <= L * v.exp_n; c++) begin
      @(negedge clk);
      k = (c - 1) / v.exp_n;
      if (txd !== frame_bit(v.data, k, v.exp_par, 1'b1)) bit_bad[k] = 1'b1;
      if (bus.uart_status[0] !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      bus.send_req = (c + 1 == v.poke);
      if (bus.send_req) bus.uart_send_byte = 8'hFF;
    end
    for (int b = 0; b < L; b++) begin
      check_output($sformatf("tx%0d_bit%0d_wrong", idx, b), 32'(bit_bad[b]), 0);
    end
    check_output($sformatf("tx%0d_busy_dropped", idx), 32'(busy_bad), 0);
    @(negedge clk);
    check_output($sformatf("tx%0d_busy_end", idx), 32'(bus.uart_status[0]), 0);
    check_output($sformatf("tx%0d_txd_idle", idx), 32'(txd), 1);
  endtask

  // Drives one RX frame on rxd starting with the start bit on cycle 0.
  task automatic drive_rx_frame(input logic [7:0] d, input int n, input logic stop_v,
                                input logic flip, input int clr_at,
                                output logic v_stop, output logic v_after);
    int   stop_cyc;
    logic par;
    stop_cyc = 2 + n / 2 + (L - 1) * n;
    par      = (^d) ^ flip;
    v_stop   = 1'b0;
    v_after  = 1'b0;
    bus.uart_cfg = 8'(n);
    for (int c = 0; c < L * n + n; c++) begin
      rxd_tb     = frame_bit(d, c / n, par, stop_v);
      bus.rx_clr = (c == clr_at);
      if (c == 3) bus.uart_cfg = 8'($urandom);
      @(negedge clk);
      if (c == stop_cyc) v_stop = bus.uart_status[1];
      if (c == stop_cyc + 1) v_after = bus.uart_status[1];
      @(posedge clk); #1;
    end
    bus.rx_clr = 1'b0;
    rxd_tb     = 1'b1;
    if (clr_at >= 0 && clr_at < stop_cyc) model_clear();
    model_frame(d, ~stop_v, PAR & flip, clr_at == stop_cyc);
  endtask

  task automatic drive_glitch(input int len, input int n);
    bus.uart_cfg = 8'(n);
    for (int c = 0; c < len + 2 * n; c++) begin
      rxd_tb = (c < len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clr();
    bus.rx_clr = 1'b1;
    @(posedge clk); #1;
    bus.rx_clr = 1'b0;
    model_clear();
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp_byte, input logic [7:0] exp_stat);
    @(negedge clk);
    check_output({name, "_byte"}, 32'(bus.uart_rcvd_byte), 32'(exp_byte));
    check_output({name, "_status"}, 32'(bus.uart_status), 32'(exp_stat));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic vs, va;
    int   n, mode, stop_cyc, clr_at;
    logic [7:0] d;
    logic sv, fl;

    tx_tab[0] = '{8'hA5, 8'd18, 40, 18, 1'b0};
    tx_tab[1] = '{8'h07, 8'd0,  3,  2,  1'b1};
    tx_tab[2] = '{8'h3C, 8'd1,  0,  2,  1'b0};
    tx_tab[3] = '{8'hFF, 8'd5,  12, 5,  1'b0};
    tx_tab[4] = '{8'h00, 8'd3,  0,  3,  1'b0};
    tx_tab[5] = '{8'h80, 8'd2,  7,  2,  1'b1};

    bus.send_req       = 1'b0;
    bus.uart_send_byte = 8'h00;
    bus.uart_cfg       = 8'd18;
    bus.rx_clr         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    check_output("reset_txd", 32'(txd), 1);
    check_output("reset_status", 32'(bus.uart_status), 0);
    check_output("reset_rcvd", 32'(bus.uart_rcvd_byte), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tx_tab[i], i);
    end
    @(posedge clk); #1;

    // Loopback of a full frame through the receiver.
    loop_en = 1'b1;
    bus.uart_cfg       = 8'd18;
    bus.uart_send_byte = 8'h3C;
    bus.send_req       = 1'b1;
    @(posedge clk); #1;
    bus.send_req = 1'b0;
    repeat (12 * 18) @(posedge clk);
    #1;
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_rx("loop", 8'h3C, 8'h02);
    loop_en = 1'b0;
    pulse_clr();
    check_rx("loop_clr", 8'h3C, 8'h00);

    drive_rx_frame(8'h11, 18, 1'b1, 1'b0, -1, vs, va);
    check_output("rx_lat_at_stop", 32'(vs), 0);
    check_output("rx_lat_after", 32'(va), 1);
    drive_rx_frame(8'h22, 18, 1'b1, 1'b0, -1, vs, va);
    check_rx("overrun", 8'h11, 8'h06);
    drive_rx_frame(8'h33, 18, 1'b1, 1'b0, 2 + 9 + (L - 1) * 18, vs, va);
    check_rx("clr_on_done", 8'h33, 8'h02);

    pulse_clr();
    drive_rx_frame(8'h55, 18, 1'b0, 1'b0, -1, vs, va);
    check_rx("frame_err", 8'h55, 8'h0A);
    drive_glitch(3, 18);
    check_rx("glitch", 8'h55, 8'h0A);
    pulse_clr();
    check_rx("clr_err", 8'h55, 8'h00);

    drive_rx_frame(8'h5A, 12, 1'b1, 1'b1, -1, vs, va);
    check_rx("parity_flip", 8'h5A, PAR ? 8'h12 : 8'h02);
    pulse_clr();

    for (int i = 0; i < 24; i++) begin
      d        = 8'($urandom);
      n        = 6 + $urandom_range(0, 14);
      sv       = ($urandom_range(0, 4) != 0);
      fl       = ($urandom_range(0, 3) == 0);
      mode     = $urandom_range(0, 3);
      stop_cyc = 2 + n / 2 + (L - 1) * n;
      clr_at   = (mode == 1) ? stop_cyc : (mode == 2) ? n : -1;
      drive_rx_frame(d, n, sv, fl, clr_at, vs, va);
      check_rx($sformatf("rand%0d", i), m_byte, model_status());
    end

    // Asynchronous reset in the middle of a looped-back frame.
    loop_en = 1'b1;
    bus.uart_cfg       = 8'd20;
    bus.uart_send_byte = 8'hAA;
    bus.send_req       = 1'b1;
    @(posedge clk); #1;
    bus.send_req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_output("rst_pre_txd", 32'(txd), 0);
    rstb = 1'b0;
    #1;
    check_output("rst_txd", 32'(txd), 1);
    check_output("rst_status", 32'(bus.uart_status), 0);
    check_output("rst_rcvd", 32'(bus.uart_rcvd_byte), 0);
    m_byte = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rstb    = 1'b1;
    loop_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drive_rx_frame(8'hC3, 8, 1'b1, 1'b0, -1, vs, va);
    check_rx("post_rst", 8'hC3, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
